// File: rtl/pipe_stage_buf_pkg.sv
// Shared constants for the pipeline stage buffer and the CPU stage payloads.
// D/E/M/W bundle widths and packed field offsets live here so each stage
// payload is assembled by concatenation in exactly one place.
package pipe_stage_buf_pkg;

  // Occupancy counter width (0..2 entries)
  localparam int OCC_W   = 2;

  // Basic field widths
  localparam int PC_W    = 32;
  localparam int INST_W  = 32;
  localparam int XLEN    = 32;
  localparam int RID_W   = 5;
  localparam int CTRL_W  = 8;

  // D bundle: {pc, inst}
  localparam int D_INST_LSB = 0;
  localparam int D_PC_LSB   = D_INST_LSB + INST_W;
  localparam int D_BUS_W    = D_PC_LSB + PC_W;

  // E bundle: {pc, ctrl, rd, src2, src1}
  localparam int E_SRC1_LSB = 0;
  localparam int E_SRC2_LSB = E_SRC1_LSB + XLEN;
  localparam int E_RD_LSB   = E_SRC2_LSB + XLEN;
  localparam int E_CTRL_LSB = E_RD_LSB + RID_W;
  localparam int E_PC_LSB   = E_CTRL_LSB + CTRL_W;
  localparam int E_BUS_W    = E_PC_LSB + PC_W;

  // M bundle: {pc, rd, alu_res}
  localparam int M_RES_LSB  = 0;
  localparam int M_RD_LSB   = M_RES_LSB + XLEN;
  localparam int M_PC_LSB   = M_RD_LSB + RID_W;
  localparam int M_BUS_W    = M_PC_LSB + PC_W;

  // W bundle: {pc, we, rd, wb_data}
  localparam int W_DATA_LSB = 0;
  localparam int W_RD_LSB   = W_DATA_LSB + XLEN;
  localparam int W_WE_LSB   = W_RD_LSB + RID_W;
  localparam int W_PC_LSB   = W_WE_LSB + 1;
  localparam int W_BUS_W    = W_PC_LSB + PC_W;

endpackage

// File: rtl/pipe_stage_buf_entry.sv
// pipe_entry_reg: one valid bit plus payload register.
//   clk, reset  : clock, async active-high reset (valid=0, payload=RST_VAL)
//   i_clr       : synchronous clear of the valid bit (wins over i_load)
//   i_load      : load i_valid / i_data this edge
//   o_valid, o_data : registered entry
module pipe_entry_reg
  import pipe_stage_buf_pkg::*;
#(
  parameter int                DATA_W  = 32,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clr,
  input  logic              i_load,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= RST_VAL;
    end else begin
      // Payload is don't-care on clear, so it simply follows i_load
      if (i_load) r_data <= i_data;
      if (i_clr)       r_valid <= 1'b0;
      else if (i_load) r_valid <= i_valid;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: generic pipeline stage register with optional skid entry.
//   clk, reset             : clock, async active-high reset
//   flush                  : synchronous kill of all held entries
//   prev_to_this_valid     : upstream offers an entry
//   this_allow_in          : stage accepts this cycle
//   data_i / data_o        : incoming / head payload
//   ready_go               : head finished its work here
//   this_to_next_valid     : head offered downstream
//   next_allow_in          : downstream accepts
//   head_valid, occupancy  : head occupied / number of held entries
module pipe_stage_buf
  import pipe_stage_buf_pkg::*;
#(
  parameter int             DATA_W   = 32,
  parameter int             SKID     = 0,
  parameter int             MASK_OUT = 1,
  parameter logic [1023:0]  RST_DATA = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              prev_to_this_valid,
  output logic              this_allow_in,
  input  logic [DATA_W-1:0] data_i,
  input  logic              ready_go,
  output logic              this_to_next_valid,
  input  logic              next_allow_in,
  output logic [DATA_W-1:0] data_o,
  output logic              head_valid,
  output logic [OCC_W-1:0]  occupancy
);

  localparam logic [DATA_W-1:0] RST_VAL = RST_DATA[DATA_W-1:0];

  logic              w_head_vld;
  logic [DATA_W-1:0] w_head_data;
  logic              w_head_ld;
  logic              w_head_vin;
  logic [DATA_W-1:0] w_head_din;
  logic              w_skid_vld;
  logic              w_allow;
  logic              w_emit;

  assign this_to_next_valid = w_head_vld & ready_go;
  assign w_emit             = this_to_next_valid & next_allow_in;

  pipe_entry_reg #(.DATA_W(DATA_W), .RST_VAL(RST_VAL)) u_head (
    .clk     (clk),
    .reset   (reset),
    .i_clr   (flush),
    .i_load  (w_head_ld),
    .i_valid (w_head_vin),
    .i_data  (w_head_din),
    .o_valid (w_head_vld),
    .o_data  (w_head_data)
  );

  generate
    if (SKID == 0) begin : g_single
      // Combinational back-pressure: the slot frees in the same cycle it drains
      assign w_allow    = !w_head_vld | (ready_go & next_allow_in);
      assign w_head_ld  = w_allow;
      assign w_head_vin = prev_to_this_valid;
      assign w_head_din = data_i;
      assign w_skid_vld = 1'b0;
    end else begin : g_skid
      logic [DATA_W-1:0] w_skid_data;
      logic              w_skid_ld;

      // Registered back-pressure: only the skid's state gates acceptance
      assign w_allow    = !w_skid_vld;
      // Head refills on emit or when empty; a held skid entry is older than data_i
      assign w_head_ld  = w_emit | !w_head_vld;
      assign w_head_vin = w_skid_vld | prev_to_this_valid;
      assign w_head_din = w_skid_vld ? w_skid_data : data_i;
      // Skid fills when head is stuck and an entry arrives; empties on any emit
      assign w_skid_ld  = w_emit | (w_head_vld & prev_to_this_valid & !w_skid_vld);

      pipe_entry_reg #(.DATA_W(DATA_W), .RST_VAL(RST_VAL)) u_skid (
        .clk     (clk),
        .reset   (reset),
        .i_clr   (flush),
        .i_load  (w_skid_ld),
        .i_valid (!w_emit),
        .i_data  (data_i),
        .o_valid (w_skid_vld),
        .o_data  (w_skid_data)
      );
    end
  endgenerate

  assign this_allow_in = w_allow;
  assign head_valid    = w_head_vld;
  assign occupancy     = OCC_W'(w_head_vld) + OCC_W'(w_skid_vld);
  assign data_o        = (MASK_OUT != 0) ? (w_head_data & {DATA_W{w_head_vld}})
                                         : w_head_data;

  // The skid only ever holds the younger of two entries
  a_skid_needs_head: assert property (@(posedge clk) disable iff (reset)
                                      !(w_skid_vld && !w_head_vld));

endmodule

// File: tb/tb_pipe_stage_buf.sv
module tb_pipe_stage_buf;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       pv, rg, nai, fl;
  logic [1:0][63:0] di;
  wire  [1:0]       ai, tnv, hv;
  wire  [1:0][63:0] dout;
  wire  [1:0][1:0]  occ;

  int n_chk = 0;
  int n_err = 0;

  logic [63:0] q0[$];
  logic [63:0] q1[$];

  always #5 clk = ~clk;

  pipe_stage_buf #(.DATA_W(64), .SKID(0), .MASK_OUT(1)) u_dut0 (
    .clk(clk), .reset(rst), .flush(fl[0]), .prev_to_this_valid(pv[0]),
    .this_allow_in(ai[0]), .data_i(di[0]), .ready_go(rg[0]),
    .this_to_next_valid(tnv[0]), .next_allow_in(nai[0]), .data_o(dout[0]),
    .head_valid(hv[0]), .occupancy(occ[0])
  );

  pipe_stage_buf #(.DATA_W(64), .SKID(1), .MASK_OUT(1)) u_dut1 (
    .clk(clk), .reset(rst), .flush(fl[1]), .prev_to_this_valid(pv[1]),
    .this_allow_in(ai[1]), .data_i(di[1]), .ready_go(rg[1]),
    .this_to_next_valid(tnv[1]), .next_allow_in(nai[1]), .data_o(dout[1]),
    .head_valid(hv[1]), .occupancy(occ[1])
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drv(input int k, input bit p, input logic [63:0] d,
                     input bit r, input bit n, input bit f);
    pv[k] = p; di[k] = d; rg[k] = r; nai[k] = n; fl[k] = f;
  endtask

  // Reference: the stage is a FIFO of capacity 1 (SKID=0) or 2 (SKID=1).
  // Check this cycle's outputs, then advance the FIFO across the coming edge.
  task automatic eval(input int k);
    logic [63:0] q[$];
    bit e_hv, e_tnv, emit, al, acc;
    if (k == 0) q = q0; else q = q1;
    e_hv  = (q.size() != 0);
    e_tnv = e_hv && rg[k];
    emit  = e_tnv && nai[k];
    al    = (k == 0) ? (q.size() == 0 || (rg[k] && nai[k])) : (q.size() < 2);
    chk($sformatf("allow%0d", k), 64'(ai[k]),  64'(al));
    chk($sformatf("tnv%0d", k),   64'(tnv[k]), 64'(e_tnv));
    chk($sformatf("hv%0d", k),    64'(hv[k]),  64'(e_hv));
    chk($sformatf("occ%0d", k),   64'(occ[k]), 64'(q.size()));
    chk($sformatf("dout%0d", k),  dout[k],     e_hv ? q[0] : 64'h0);
    acc = pv[k] && al;
    if (fl[k]) q.delete();
    else begin
      if (emit) void'(q.pop_front());
      if (acc)  q.push_back(di[k]);
    end
    if (k == 0) q0 = q; else q1 = q;
  endtask

  // Called just after a negedge with inputs set; returns at the next negedge
  task automatic cyc();
    #1;
    eval(0);
    eval(1);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    drv(0, 0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 0);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_hv",  64'(hv[k]),  64'h0);
      chk("rst_occ", 64'(occ[k]), 64'h0);
      chk("rst_tnv", 64'(tnv[k]), 64'h0);
      chk("rst_dout", dout[k],    64'h0);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_allow0", 64'(ai[0]), 64'h1);
    chk("rst_allow1", 64'(ai[1]), 64'h1);
    @(negedge clk);

    // 1: SKID=0 back-to-back stream
    drv(0, 1, 64'h11, 1, 1, 0); cyc();
    drv(0, 1, 64'h22, 1, 1, 0); #1; chk("t1_d11", dout[0], 64'h11); chk("t1_al", 64'(ai[0]), 64'h1); cyc();
    drv(0, 1, 64'h33, 1, 1, 0); #1; chk("t1_d22", dout[0], 64'h22); cyc();
    drv(0, 0, 64'h0,  1, 1, 0); #1; chk("t1_d33", dout[0], 64'h33); cyc();
    cyc();

    // 2: SKID=1 fill to two, stall upstream, then drain in order
    drv(1, 1, 64'hA1, 1, 0, 0); cyc();
    drv(1, 1, 64'hA2, 1, 0, 0); #1; chk("t2_occ1", 64'(occ[1]), 64'h1); cyc();
    drv(1, 1, 64'hA3, 1, 0, 0); #1; chk("t2_occ2", 64'(occ[1]), 64'h2); chk("t2_al0", 64'(ai[1]), 64'h0); cyc();
    drv(1, 1, 64'hA3, 1, 1, 0); #1; chk("t2_oA1", dout[1], 64'hA1); cyc();
    drv(1, 1, 64'hA3, 1, 1, 0); #1; chk("t2_oA2", dout[1], 64'hA2); chk("t2_al1", 64'(ai[1]), 64'h1); cyc();
    drv(1, 0, 64'h0,  1, 1, 0); #1; chk("t2_oA3", dout[1], 64'hA3); cyc();
    #1; chk("t2_empty", 64'(hv[1]), 64'h0); cyc();

    // 3: flush at occupancy 2 with a simultaneous offer
    drv(1, 1, 64'hB1, 1, 0, 0); cyc();
    drv(1, 1, 64'hB2, 1, 0, 0); cyc();
    drv(1, 1, 64'h5C, 1, 0, 1); #1; chk("t3_occ2", 64'(occ[1]), 64'h2); cyc();
    drv(1, 0, 64'h0,  1, 1, 0); #1;
    chk("t3_occ", 64'(occ[1]), 64'h0); chk("t3_hv", 64'(hv[1]), 64'h0); chk("t3_dout", dout[1], 64'h0);
    cyc();
    cyc();

    // 4: ready_go low holds the head, then one emit
    drv(0, 1, 64'h77, 0, 1, 0); drv(1, 1, 64'h77, 0, 1, 0); cyc();
    drv(0, 0, 64'h0, 0, 1, 0);  drv(1, 0, 64'h0, 0, 1, 0);
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("t4_tnv0", 64'(tnv[0]), 64'h0); chk("t4_hv0", 64'(hv[0]), 64'h1);
      chk("t4_tnv1", 64'(tnv[1]), 64'h0); chk("t4_hv1", 64'(hv[1]), 64'h1);
      cyc();
    end
    drv(0, 0, 64'h0, 1, 1, 0);  drv(1, 0, 64'h0, 1, 1, 0);
    #1; chk("t4_emit0", dout[0], 64'h77); chk("t4_emit1", dout[1], 64'h77); cyc();
    #1; chk("t4_once0", 64'(tnv[0]), 64'h0); chk("t4_once1", 64'(tnv[1]), 64'h0); cyc();

    // 5: asynchronous reset between edges while full
    drv(0, 0, 64'h0, 1, 1, 0);
    drv(1, 1, 64'hC1, 1, 0, 0); cyc();
    drv(1, 1, 64'hC2, 1, 0, 0); cyc();
    drv(1, 0, 64'h0,  1, 0, 0);
    #1; chk("t5_occ2", 64'(occ[1]), 64'h2);
    #1; rst = 1'b1;
    #1;
    chk("t5_hv",  64'(hv[1]),  64'h0);
    chk("t5_occ", 64'(occ[1]), 64'h0);
    chk("t5_tnv", 64'(tnv[1]), 64'h0);
    chk("t5_dout", dout[1],    64'h0);
    q0.delete(); q1.delete();
    @(negedge clk);
    #2; rst = 1'b0;
    #1; chk("t5_allow", 64'(ai[1]), 64'h1);
    @(negedge clk);

    // 6: random traffic on both variants
    for (int c = 0; c < 10000; c++) begin
      for (int k = 0; k < 2; k++)
        drv(k, ($urandom_range(0, 99) < 60), {$urandom, $urandom},
            ($urandom_range(0, 99) < 75), ($urandom_range(0, 99) < 60),
            ($urandom_range(0, 99) < 3));
      if (c % 50 == 0) begin
        // SKID=1 acceptance must not react to next_allow_in
        #1; nai[1] = ~nai[1];
        #1; chk("t6_allow_reg", 64'(ai[1]), 64'(q1.size() < 2));
        nai[1] = ~nai[1];
      end
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
Generic, parametrised pipeline stage register for the CPU datapath. It replaces hand-written per-stage valid/allow_in logic with one block.
- Carries a flat payload bus between stages.
- Optional second entry (skid) removes the combinational path from next_allow_in back to this_allow_in.
- Supports synchronous flush and async reset, plus optional masking of the payload when the stage holds no valid entry.

Parameters:
DATA_W, 32, payload width in bits (1..1024).
SKID, 0, 0 = single-entry stage; 1 = two-entry stage with registered this_allow_in.
MASK_OUT, 1, 1 = data_o forced to 0 when the head entry is not valid; 0 = raw head register.
RST_DATA, 0, payload reset value, zero-extended or truncated to DATA_W.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high reset.
flush  in  1  synchronous kill of all held entries (exception/eret redirect).
prev_to_this_valid  in  1  upstream offers an entry this cycle.
this_allow_in  out  1  stage accepts an entry this cycle.
data_i  in  DATA_W  incoming payload.
ready_go  in  1  head entry has finished its work in this stage.
this_to_next_valid  out  1  head entry offered downstream.
next_allow_in  in  1  downstream accepts.
data_o  out  DATA_W  head payload.
head_valid  out  1  head entry occupied, regardless of ready_go.
occupancy  out  2  number of held entries (0..2; 0..1 when SKID=0).

Behaviour:
- Reset (async, any time including mid-transfer):
  - head_valid = 0, skid valid = 0, occupancy = 0.
  - Payload registers = RST_DATA.
  - this_to_next_valid = 0.
  - this_allow_in = 1 as soon as reset deasserts.
- Transfer rules:
  - Accept when prev_to_this_valid && this_allow_in.
  - Emit when this_to_next_valid && next_allow_in.
  - this_to_next_valid = head_valid && ready_go.
  - Latency: an entry accepted in cycle N is at the head in cycle N+1.
- SKID=0:
  - this_allow_in = !head_valid || (ready_go && next_allow_in). This is combinational.
  - When this_allow_in is high, head_valid <= prev_to_this_valid and head payload <= data_i. The payload is loaded even if the entry is invalid.
- SKID=1:
  - this_allow_in = !skid_valid. This is purely registered.
  - Emit with skid_valid = 1: head <= skid and skid empties. No accept is possible that cycle.
  - Emit with skid empty: head <= data_i and head_valid <= prev_to_this_valid.
  - No emit, head empty: head <= data_i and head_valid <= prev_to_this_valid.
  - No emit, head full, accept: skid <= data_i and skid_valid <= 1.
  - Order is preserved: skid is always younger than head.
- Flush (synchronous):
  - All valid bits clear at the edge.
  - Overrides any accept in the same cycle; the incoming entry is dropped and never appears at the head.
  - Payload registers are don't-care and do not need to be cleared.
- Output masking:
  - MASK_OUT=1: data_o = head payload & {DATA_W{head_valid}}.
  - MASK_OUT=0: data_o = head payload.
- occupancy = head_valid + skid_valid. A value of 2 implies this_allow_in = 0.
- ready_go low with head_valid high holds the head indefinitely.
  - SKID=1 then admits exactly one more entry before this_allow_in drops.
- Boundary conditions:
  - Full (occupancy 2) with simultaneous emit: no accept; occupancy becomes 1.
  - Empty with simultaneous accept and downstream ready: the entry lands at the head and does not bypass the stage.
  - Assertion: the skid entry can be valid only while head_valid is high.

Decomposition:
- Shared package constants for pipeline payload widths and packed field offsets of the D/E/M/W bundles, so stage payloads are built by concatenation in one place.
- The occupancy width constant (2) also goes in the package.
- No typedefs are required beyond the packed bundle widths.
- One natural sub-module, pipe_entry_reg: a single valid+payload register with load enable, async reset and sync clear. It is instantiated once for the head and once for the skid (under a generate when SKID=1).

Test Plan:
1. SKID=0, DATA_W=8, ready_go=1, next_allow_in=1; stream 0x11, 0x22, 0x33 back-to-back -> data_o shows 0x11, 0x22, 0x33 on consecutive cycles one cycle after input; this_allow_in stays 1.
2. SKID=1; load 0xA1, then hold next_allow_in=0 and offer 0xA2, 0xA3 -> occupancy goes 1, 2; this_allow_in drops after 0xA2 is accepted; 0xA3 is held upstream. Release next_allow_in -> order out is 0xA1, 0xA2, 0xA3 with no loss or duplication.
3. SKID=1, occupancy=2, assert flush together with prev_to_this_valid=1 and data 0x5C -> next cycle occupancy=0, head_valid=0, data_o=0 (MASK_OUT=1); 0x5C never emitted.
4. ready_go=0 with head 0x77 for 5 cycles -> this_to_next_valid=0 throughout while head_valid=1; raising ready_go emits 0x77 exactly once.
5. Assert reset asynchronously (between clock edges) while occupancy=2 -> head_valid, occupancy and this_to_next_valid go to 0 before the next edge; data_o=RST_DATA masked to 0.
6. Random stimulus on all valid/ready/flush inputs for 10k cycles, DATA_W=64, both SKID values -> scoreboard shows in-order, lossless, no-duplicate delivery excluding flushed entries; no combinational dependence of this_allow_in on next_allow_in when SKID=1.
